// File: rtl/trigger_burst_gen_pkg.sv
// Shared definitions for the trigger burst generator: FSM state encoding
// and default counter widths.
package trigger_burst_gen_pkg;

   localparam int COUNT_WIDTH_DEF = 32;
   localparam int BURST_WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      HIGH  = 2'd2,
      LOW   = 2'd3
   } state_t;

endpackage

// File: rtl/trigger_burst_gen_sat_counter.sv
// Saturating up-counter with synchronous clear. Holds at all-ones once
// reached; clear has priority over increment.
module trigger_burst_gen_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // Count events, sticking at the maximum value.
   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/trigger_burst_gen.sv
// Trigger-to-burst generator. Each accepted trigger starts a programmable
// delay followed by N pulses of programmable high width and low gap.
// Triggers that arrive while a burst is running are counted as overruns.
module trigger_burst_gen
   import trigger_burst_gen_pkg::*;
#(
   parameter int COUNT_WIDTH = COUNT_WIDTH_DEF,
   parameter int BURST_WIDTH = BURST_WIDTH_DEF
) (
   input  logic                   ipClk,
   input  logic                   ipReset,
   input  logic                   ipTrigger,
   input  logic                   ipEnable,
   input  logic [COUNT_WIDTH-1:0] ipDelay,
   input  logic [COUNT_WIDTH-1:0] ipWidth,
   input  logic [COUNT_WIDTH-1:0] ipGap,
   input  logic [BURST_WIDTH-1:0] ipCount,
   output logic                   opPulse,
   output logic                   opBusy,
   output logic                   opDone,
   output logic [BURST_WIDTH-1:0] opOverrun
);

   localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);
   localparam logic [BURST_WIDTH-1:0] BURST_ONE = BURST_WIDTH'(1);

   logic                   rst;
   state_t                 state;
   state_t                 state_next;
   logic [COUNT_WIDTH-1:0] phase_cnt;
   logic [COUNT_WIDTH-1:0] width_q;
   logic [COUNT_WIDTH-1:0] gap_q;
   logic [BURST_WIDTH-1:0] pulse_cnt;
   logic                   done_q;
   logic                   accept;
   logic                   phase_last;
   logic                   last_pulse;
   logic                   overrun_inc;
   logic [BURST_WIDTH-1:0] overrun_count;

   // A trigger starts a burst only when enabled and the burst is non-empty.
   assign accept      = ipTrigger && ipEnable && (ipWidth != '0) && (ipCount != '0);
   assign phase_last  = (phase_cnt == CNT_ONE);
   assign last_pulse  = (pulse_cnt == BURST_ONE);
   assign overrun_inc = ipTrigger && (state != IDLE);

   // Register the external reset once; the registered copy drives all logic.
   always_ff @(posedge ipClk) begin
      rst <= ipReset;
   end

   // State register.
   always_ff @(posedge ipClk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode: each timed phase ends when its counter reaches 1.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = (ipDelay != '0) ? DELAY : HIGH;
            end
         end
         DELAY: begin
            if (phase_last) begin
               state_next = HIGH;
            end
         end
         HIGH: begin
            if (phase_last) begin
               state_next = last_pulse ? IDLE : LOW;
            end
         end
         LOW: begin
            if (phase_last) begin
               state_next = HIGH;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Phase and pulse counters plus latched burst shape; the shape is captured
   // at accept so later input changes cannot disturb a running burst.
   always_ff @(posedge ipClk) begin
      if (rst) begin
         phase_cnt <= '0;
         pulse_cnt <= '0;
         width_q   <= '0;
         gap_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  width_q   <= ipWidth;
                  gap_q     <= (ipGap == '0) ? CNT_ONE : ipGap;
                  pulse_cnt <= ipCount;
                  phase_cnt <= (ipDelay != '0) ? ipDelay : ipWidth;
               end
            end
            DELAY: begin
               if (phase_last) begin
                  phase_cnt <= width_q;
               end else begin
                  phase_cnt <= phase_cnt - CNT_ONE;
               end
            end
            HIGH: begin
               if (phase_last) begin
                  pulse_cnt <= pulse_cnt - BURST_ONE;
                  if (last_pulse) begin
                     phase_cnt <= '0;
                     done_q    <= 1'b1;
                  end else begin
                     phase_cnt <= gap_q;
                  end
               end else begin
                  phase_cnt <= phase_cnt - CNT_ONE;
               end
            end
            LOW: begin
               if (phase_last) begin
                  phase_cnt <= width_q;
               end else begin
                  phase_cnt <= phase_cnt - CNT_ONE;
               end
            end
            default: phase_cnt <= '0;
         endcase
      end
   end

   trigger_burst_gen_sat_counter #(
      .WIDTH (BURST_WIDTH)
   ) u_overrun (
      .clk   (ipClk),
      .clear (rst),
      .inc   (overrun_inc),
      .count (overrun_count)
   );

   // Outputs decode from registers only; the registered reset forces them
   // low from the first cycle it is seen, so a mid-burst reset emits no done.
   always_comb begin
      opPulse   = (state == HIGH) && !rst;
      opBusy    = (state != IDLE) && !rst;
      opDone    = done_q && !rst;
      opOverrun = rst ? '0 : overrun_count;
   end

endmodule

// File: tb/tb_trigger_burst_gen.sv
// Bench for trigger_burst_gen: expected per-cycle outputs are built from the
// burst timing formula, queued as stimulus is driven, and compared as the
// DUT produces each cycle.
module tb_trigger_burst_gen;

   typedef struct packed {
      logic        p;
      logic        b;
      logic        d;
      logic [15:0] ov;
   } exp_t;

   logic        clk = 1'b0;
   logic        ipReset, ipTrigger, ipEnable;
   logic [31:0] ipDelay, ipWidth, ipGap;
   logic [15:0] ipCount;
   logic        opPulse, opBusy, opDone;
   logic [15:0] opOverrun;
   logic        pulse_s, busy_s, done_s;
   logic [1:0]  ov_s;

   int n_tests = 0;
   int n_fail  = 0;
   int cur_cyc = 0;

   exp_t sb_q[$];

   bit   exp_p [64];
   bit   exp_b [64];
   bit   exp_d [64];
   bit   trig  [64];
   bit   rst_in[64];
   bit   chg   [64];
   logic [15:0] ov_model = '0;

   trigger_burst_gen #(.COUNT_WIDTH(32), .BURST_WIDTH(16)) dut (
      .ipClk(clk), .ipReset(ipReset), .ipTrigger(ipTrigger), .ipEnable(ipEnable),
      .ipDelay(ipDelay), .ipWidth(ipWidth), .ipGap(ipGap), .ipCount(ipCount),
      .opPulse(opPulse), .opBusy(opBusy), .opDone(opDone), .opOverrun(opOverrun));

   trigger_burst_gen #(.COUNT_WIDTH(32), .BURST_WIDTH(2)) dut_sat (
      .ipClk(clk), .ipReset(ipReset), .ipTrigger(ipTrigger), .ipEnable(ipEnable),
      .ipDelay(ipDelay), .ipWidth(ipWidth), .ipGap(ipGap), .ipCount(ipCount[1:0]),
      .opPulse(pulse_s), .opBusy(busy_s), .opDone(done_s), .opOverrun(ov_s));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cur_cyc, obs, exp);
      end
   endtask

   // Pop one expected entry per cycle and compare against the DUT.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk("pulse",   32'(opPulse),   32'(e.p));
         chk("busy",    32'(opBusy),    32'(e.b));
         chk("done",    32'(opDone),    32'(e.d));
         chk("overrun", 32'(opOverrun), 32'(e.ov));
      end
   end

   task automatic clear_tb();
      for (int i = 0; i < 64; i++) begin
         exp_p[i] = 0; exp_b[i] = 0; exp_d[i] = 0;
         trig[i] = 0; rst_in[i] = 0; chg[i] = 0;
      end
   endtask

   task automatic set_cfg(input int d, input int w, input int g, input int n);
      ipDelay = d; ipWidth = w; ipGap = g; ipCount = 16'(n);
   endtask

   // Expected waveform for a burst accepted in window cycle t0.
   task automatic burst_expect(input int t0, input int d, input int w, input int g, input int n);
      int ge, last;
      ge   = (g == 0) ? 1 : g;
      last = t0 + d + w + (n - 1) * (w + ge);
      for (int k = 0; k < n; k++)
         for (int i = 0; i < w; i++)
            exp_p[t0 + 1 + d + k * (w + ge) + i] = 1;
      for (int c = t0 + 1; c <= last; c++) exp_b[c] = 1;
      exp_d[last + 1] = 1;
   endtask

   // Drive one window cycle by cycle, queueing the expected outputs.
   task automatic run_window(input int len);
      int   kill_from;
      exp_t e;
      kill_from = 1000;
      for (int c = 0; c < len; c++) begin
         @(posedge clk); #1;
         cur_cyc   = c;
         ipTrigger = trig[c];
         ipReset   = rst_in[c];
         if (rst_in[c]) kill_from = c + 1;
         if (chg[c]) begin
            ipWidth = $urandom_range(1, 9);
            ipCount = 16'($urandom_range(1, 3));
            ipDelay = $urandom_range(0, 5);
            ipGap   = $urandom_range(0, 5);
         end
         if (c >= kill_from) begin
            ov_model = '0;
            e = '{p: 1'b0, b: 1'b0, d: 1'b0, ov: 16'h0};
         end else begin
            e = '{p: exp_p[c], b: exp_b[c], d: exp_d[c], ov: ov_model};
            if (trig[c] && exp_b[c] && ov_model != 16'hFFFF) ov_model = ov_model + 1'b1;
         end
         sb_q.push_back(e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cur_cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      ipReset = 1'b1; ipTrigger = 1'b0; ipEnable = 1'b1;
      set_cfg(0, 1, 1, 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_pulse",   32'(opPulse),   0);
      chk("rst_busy",    32'(opBusy),    0);
      chk("rst_done",    32'(opDone),    0);
      chk("rst_overrun", 32'(opOverrun), 0);
      @(posedge clk); #1 ipReset = 1'b0;
      repeat (2) @(posedge clk);

      // Basic burst
      clear_tb(); set_cfg(0, 2, 3, 3);
      trig[10] = 1; burst_expect(10, 0, 2, 3, 3);
      run_window(30);

      // Delay with zero gap
      clear_tb(); set_cfg(4, 1, 0, 2);
      trig[0] = 1; burst_expect(0, 4, 1, 0, 2);
      run_window(15);

      // Overrun: two triggers dropped
      clear_tb(); set_cfg(0, 10, 1, 1);
      trig[0] = 1; trig[3] = 1; trig[5] = 1; burst_expect(0, 0, 10, 1, 1);
      run_window(15);
      @(negedge clk);
      chk("sat_ov_a", 32'(ov_s), 2);

      // Overrun: five more while busy, narrow counter saturates
      clear_tb(); set_cfg(0, 10, 1, 1);
      trig[0] = 1; for (int i = 2; i <= 6; i++) trig[i] = 1;
      burst_expect(0, 0, 10, 1, 1);
      run_window(15);
      @(negedge clk);
      chk("sat_ov_b", 32'(ov_s), 3);

      // Back-to-back: trigger in done cycle accepted, in last HIGH dropped
      clear_tb(); set_cfg(0, 2, 1, 2);
      trig[2] = 1; burst_expect(2, 0, 2, 1, 2);
      trig[8] = 1; burst_expect(8, 0, 2, 1, 2);
      trig[13] = 1;
      run_window(20);

      // Ignore cases
      clear_tb(); set_cfg(0, 2, 1, 2); ipEnable = 1'b0; trig[1] = 1;
      run_window(6);
      ipEnable = 1'b1;
      clear_tb(); set_cfg(0, 0, 1, 2); trig[1] = 1;
      run_window(6);
      clear_tb(); set_cfg(0, 2, 1, 0); trig[1] = 1;
      run_window(6);

      // Config changes mid-burst do not alter the shape
      clear_tb(); set_cfg(1, 3, 2, 3);
      trig[1] = 1; burst_expect(1, 1, 3, 2, 3);
      for (int i = 2; i < 16; i++) chg[i] = 1;
      run_window(25);

      // Reset during the second HIGH phase, then a clean burst
      clear_tb(); set_cfg(0, 2, 2, 3);
      trig[1] = 1; trig[4] = 1; burst_expect(1, 0, 2, 2, 3);
      rst_in[6] = 1;
      run_window(16);
      clear_tb(); set_cfg(1, 2, 1, 2);
      trig[1] = 1; burst_expect(1, 1, 2, 1, 2);
      run_window(12);

      for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
      chk("drain", 32'(sb_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
